s4_frame_sequencer: RTL and testbench



---
 rtl/s4_seq_pkg.sv | 22 ++
 rtl/s4_byte_accumulator.sv | 48 ++++
 rtl/s4_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_s4_frame_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/s4_seq_pkg.sv
// s4_seq_pkg: shared constants for the stage-4 frame sequencer.
//   - FSM state encoding (3-bit binary)
//   - maximum legal bytes per cycle from the carry bitstream
//   - illegal carry-count detection helper
package s4_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_FINAL_A = 3'd2;
    localparam logic [2:0] ST_FINAL_B = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [2:0] S4_MAX_BYTES_PER_CYCLE = 3'd5;
    // Smallest carry count that cannot come out of the carry bitstream.
    localparam logic [2:0] S4_ILLEGAL_COUNT_MIN   = S4_MAX_BYTES_PER_CYCLE + 3'd1;

    function automatic logic is_illegal_count(input logic [2:0] count);
        return count >= S4_ILLEGAL_COUNT_MIN;
    endfunction

endpackage

// File: rtl/s4_byte_accumulator.sv
// s4_byte_accumulator: saturating, clearable per-frame byte counter.
// Ports:
//   clk, rst      clock, async active-high reset
//   clear         zero the counter (first accept of a frame)
//   enable        add carry_count this cycle
//   carry_count   bytes emitted this cycle (0..5 legal)
//   byte_count    running total, saturates at all-ones
//   err_count     sticky flag: an illegal carry_count was added
module s4_byte_accumulator
    import s4_seq_pkg::*;
#(
    parameter int unsigned BYTE_CNT_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [2:0]                carry_count,
    output logic [BYTE_CNT_WIDTH-1:0] byte_count,
    output logic                      err_count
);

    logic                    illegal;
    logic [2:0]              addend;
    logic [BYTE_CNT_WIDTH:0] sum;

    assign illegal = is_illegal_count(carry_count);
    assign addend  = illegal ? 3'd0 : carry_count;
    // One extra bit catches the carry-out that triggers saturation.
    assign sum     = {1'b0, byte_count} + {{(BYTE_CNT_WIDTH-2){1'b0}}, addend};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= '0;
            err_count  <= 1'b0;
        end else begin
            if (clear) begin
                byte_count <= '0;
            end else if (enable) begin
                byte_count <= sum[BYTE_CNT_WIDTH] ? '1 : sum[BYTE_CNT_WIDTH-1:0];
            end
            if (enable && illegal) begin
                err_count <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/s4_frame_sequencer.sv
// s4_frame_sequencer: stage-4 frame-level sequencer, one per encoder lane.
// Optional drain watchdog enabled by macro S4_SEQ_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for the first symbol of a frame
// RUN      | accepting symbols until one carries in_last
// FINAL_A  | final-bits capture (s4_final_flag_2_3)
// FINAL_B  | final-bits injection (s4_final_flag)
// DRAIN    | waiting for stage_4 to retire its last byte
// DONE     | one-cycle end-of-frame (seq_done)
//
// Ports:
//   s4_clk, s4_reset      clock, async active-high reset
//   in_valid, in_last     stage-3 symbol handshake; seq_ready back-pressure
//   in_carry_count        bytes emitted by stage_4 this cycle
//   in_flag_last          stage_4 last-byte flag (honoured only in DRAIN)
//   s4_flag_first, s4_final_flag_2_3, s4_final_flag   control strobes
//   seq_busy, seq_done    frame status
//   byte_count            bytes emitted in current/last frame
//   err_count, err_timeout  sticky error flags
module s4_frame_sequencer
    import s4_seq_pkg::*;
#(
    parameter int unsigned BYTE_CNT_WIDTH = 20,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TIMEOUT_WIDTH  = 7
) (
    input  logic                      s4_clk,
    input  logic                      s4_reset,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      seq_ready,
    input  logic [2:0]                in_carry_count,
    input  logic                      in_flag_last,
    output logic                      s4_flag_first,
    output logic                      s4_final_flag_2_3,
    output logic                      s4_final_flag,
    output logic                      seq_busy,
    output logic                      seq_done,
    output logic [BYTE_CNT_WIDTH-1:0] byte_count,
    output logic                      err_count,
    output logic                      err_timeout
);

    if ((2 ** TIMEOUT_WIDTH) <= TIMEOUT_CYCLES) begin : g_bad_timeout_width
        $error("TIMEOUT_WIDTH too small for TIMEOUT_CYCLES");
    end

    logic [2:0] state;
    logic [2:0] next_state;
    logic       accept;
    logic       wd_expire;

    assign seq_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign accept    = in_valid && seq_ready;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (accept) next_state = in_last ? ST_FINAL_A : ST_RUN;
            ST_RUN:     if (accept && in_last) next_state = ST_FINAL_A;
            ST_FINAL_A: next_state = ST_FINAL_B;
            ST_FINAL_B: next_state = ST_DRAIN;
            ST_DRAIN:   if (in_flag_last || wd_expire) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge s4_clk or posedge s4_reset) begin
        if (s4_reset) begin
            state             <= ST_IDLE;
            s4_flag_first     <= 1'b0;
            s4_final_flag_2_3 <= 1'b0;
            s4_final_flag     <= 1'b0;
            seq_done          <= 1'b0;
            seq_busy          <= 1'b0;
        end else begin
            state             <= next_state;
            s4_flag_first     <= (state == ST_IDLE) && accept;
            s4_final_flag_2_3 <= (next_state == ST_FINAL_A);
            s4_final_flag     <= (next_state == ST_FINAL_B);
            seq_done          <= (next_state == ST_DONE);
            seq_busy          <= (next_state != ST_IDLE);
        end
    end

`ifdef S4_SEQ_TIMEOUT_EN
    // Down-counter loaded while in FINAL_B so it holds TIMEOUT_CYCLES on the
    // first DRAIN cycle; reaching zero in DRAIN is the terminal count.
    logic [TIMEOUT_WIDTH-1:0] wd_cnt;

    assign wd_expire = (state == ST_DRAIN) && (wd_cnt == '0);

    always_ff @(posedge s4_clk or posedge s4_reset) begin
        if (s4_reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == ST_FINAL_B) begin
                wd_cnt <= TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
            end else if ((state == ST_DRAIN) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (wd_expire && !in_flag_last) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    s4_byte_accumulator #(
        .BYTE_CNT_WIDTH (BYTE_CNT_WIDTH)
    ) u_acc (
        .clk         (s4_clk),
        .rst         (s4_reset),
        .clear       ((state == ST_IDLE) && accept),
        .enable      (state != ST_IDLE),
        .carry_count (in_carry_count),
        .byte_count  (byte_count),
        .err_count   (err_count)
    );

endmodule

// File: tb/tb_s4_frame_sequencer.sv
module tb_s4_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, last = 1'b0, flag_last = 1'b0;
    logic [2:0]  cc = 3'd0;
    logic        ready, first, f23, ff, busy, done, errc, errt;
    logic [19:0] bc;

    logic        b_valid = 1'b0, b_last = 1'b0, b_flag_last = 1'b0;
    logic [2:0]  b_cc = 3'd0;
    logic        b_ready, b_first, b_f23, b_ff, b_busy, b_done, b_errc, b_errt;
    logic [3:0]  b_bc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    s4_frame_sequencer #(.BYTE_CNT_WIDTH(20), .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(4)) dut (
        .s4_clk(clk), .s4_reset(rst), .in_valid(valid), .in_last(last),
        .seq_ready(ready), .in_carry_count(cc), .in_flag_last(flag_last),
        .s4_flag_first(first), .s4_final_flag_2_3(f23), .s4_final_flag(ff),
        .seq_busy(busy), .seq_done(done), .byte_count(bc),
        .err_count(errc), .err_timeout(errt));

    s4_frame_sequencer #(.BYTE_CNT_WIDTH(4)) dut_b (
        .s4_clk(clk), .s4_reset(rst), .in_valid(b_valid), .in_last(b_last),
        .seq_ready(b_ready), .in_carry_count(b_cc), .in_flag_last(b_flag_last),
        .s4_flag_first(b_first), .s4_final_flag_2_3(b_f23), .s4_final_flag(b_ff),
        .seq_busy(b_busy), .seq_done(b_done), .byte_count(b_bc),
        .err_count(b_errc), .err_timeout(b_errt));

    typedef struct {
        logic        v, l;
        logic [2:0]  cc;
        logic        fl;
        logic        first, f23, ff, done, busy, ready, errc;
        logic [19:0] bc;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_at;
        int done_cnt;

        //           v  l  cc fl  first f23 ff done busy ready errc bc
        vecs[0]  = '{1, 0, 0, 0,  1, 0, 0, 0, 1, 1, 0, 0};
        vecs[1]  = '{1, 0, 5, 0,  0, 0, 0, 0, 1, 1, 0, 5};
        vecs[2]  = '{1, 0, 3, 0,  0, 0, 0, 0, 1, 1, 0, 8};
        vecs[3]  = '{1, 1, 2, 0,  0, 1, 0, 0, 1, 0, 0, 10};
        vecs[4]  = '{1, 1, 1, 0,  0, 0, 1, 0, 1, 0, 0, 11};
        vecs[5]  = '{0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0, 11};
        vecs[6]  = '{0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 11};
        vecs[7]  = '{0, 0, 0, 1,  0, 0, 0, 1, 1, 0, 0, 11};
        vecs[8]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 11};
        vecs[9]  = '{1, 1, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{0, 0, 5, 0,  0, 0, 1, 0, 1, 0, 0, 5};
        vecs[11] = '{0, 0, 3, 0,  0, 0, 0, 0, 1, 0, 0, 8};
        vecs[12] = '{0, 0, 7, 0,  0, 0, 0, 0, 1, 0, 1, 8};
        vecs[13] = '{0, 0, 2, 1,  0, 0, 0, 1, 1, 0, 1, 10};
        vecs[14] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 10};
        vecs[15] = '{0, 0, 4, 0,  0, 0, 0, 0, 0, 1, 1, 10};
        vecs[16] = '{1, 0, 3, 0,  1, 0, 0, 0, 1, 1, 1, 0};
        vecs[17] = '{1, 1, 1, 0,  0, 1, 0, 0, 1, 0, 1, 1};
        vecs[18] = '{0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 1, 1};

        // Reset values
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {first, f23, ff, done}, 0);
        chk("rst_bc", bc, 0);
        chk("rst_errs", {errc, errt}, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            valid = vecs[i].v; last = vecs[i].l; cc = vecs[i].cc; flag_last = vecs[i].fl;
            step();
            chk($sformatf("v%0d_first", i), first, vecs[i].first);
            chk($sformatf("v%0d_f23", i), f23, vecs[i].f23);
            chk($sformatf("v%0d_ff", i), ff, vecs[i].ff);
            chk($sformatf("v%0d_done", i), done, vecs[i].done);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d_ready", i), ready, vecs[i].ready);
            chk($sformatf("v%0d_errc", i), errc, vecs[i].errc);
            chk($sformatf("v%0d_bc", i), bc, vecs[i].bc);
        end
        valid = 0; last = 0; cc = 0; flag_last = 0;

        // Reset while in FINAL_B: immediate effect, no final_flag afterwards
        rst = 1'b1;
        #1;
        chk("midrst_ff", ff, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_bc", bc, 0);
        chk("midrst_errc", errc, 0);
        step();
        rst = 1'b0;
        step();
        chk("postrst_strobes", {first, f23, ff, done}, 0);
        chk("postrst_busy", busy, 0);
        step();
        chk("postrst_strobes2", {first, f23, ff, done}, 0);

        // Drain without in_flag_last
        valid = 1; last = 1;
        step();
        valid = 0; last = 0;
        step();
        step();
        chk("drain_entry_busy", {busy, ready}, 2'b10);
        done_at = 0;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
`ifdef S4_SEQ_TIMEOUT_EN
        chk("wd_done_at", done_at, 9);
        chk("wd_done_cnt", done_cnt, 1);
        chk("wd_err_timeout", errt, 1);
        chk("wd_idle_after", busy, 0);
`else
        chk("nowd_done_cnt", done_cnt, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_err_timeout", errt, 0);
        flag_last = 1;
        step();
        flag_last = 0;
        chk("nowd_done_on_flag", done, 1);
        step();
        chk("nowd_idle_after", busy, 0);
`endif

        // Saturation on a 4-bit counter
        b_valid = 1;
        step();
        chk("sat_first", b_first, 1);
        chk("sat_clear", b_bc, 0);
        b_valid = 0; b_cc = 5;
        step(); chk("sat_bc5", b_bc, 5);
        step(); chk("sat_bc10", b_bc, 10);
        step(); chk("sat_bc15", b_bc, 15);
        step(); chk("sat_hold15", b_bc, 15);
        b_cc = 0; b_valid = 1; b_last = 1;
        step();
        chk("sat_f23", b_f23, 1);
        b_valid = 0; b_last = 0;
        step();
        step();
        b_flag_last = 1;
        step();
        chk("sat_done", b_done, 1);
        b_flag_last = 0;
        step();
        chk("sat_idle_hold", b_bc, 15);
        b_valid = 1; b_cc = 3;
        step();
        chk("sat_newframe_clear", b_bc, 0);
        b_valid = 0; b_cc = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
